// File: rtl/rom_uart_streamer_if.sv
// ----------------------------------------------------------------------------
// rom_uart_streamer_if
// Bundles the signals between the ROM-to-UART streamer and its neighbours:
// the start/busy/done control, the synchronous program ROM read port and the
// send/done handshake with the 8N1 transmitter.
//
//   start    : request to begin a dump (environment -> streamer)
//   mem_addr : ROM word address          (streamer -> ROM)
//   mem_rd   : ROM read data, 1 clk late (ROM -> streamer)
//   txbyte   : byte for the transmitter  (streamer -> transmitter)
//   senddata : one-cycle send request    (streamer -> transmitter)
//   txdone   : one-cycle frame complete  (transmitter -> streamer)
//   busy     : streamer is not idle      (streamer -> environment)
//   done     : last byte acknowledged    (streamer -> environment)
//
// master = streamer side, slave = environment (ROM, transmitter, control).
// ----------------------------------------------------------------------------
interface rom_uart_streamer_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd;
    logic [7:0]        txbyte;
    logic              senddata;
    logic              txdone;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_rd, txdone,
        output mem_addr, txbyte, senddata, busy, done
    );

    modport slave (
        output start, mem_rd, txdone,
        input  mem_addr, txbyte, senddata, busy, done
    );
endinterface

// File: rtl/rom_uart_streamer.sv
// ----------------------------------------------------------------------------
// rom_uart_streamer
// Streams program ROM words 0..LAST_WORD to an 8N1 UART transmitter, one byte
// at a time, least significant byte first. Each byte is offered with a
// single-cycle senddata and the next one is only prepared after the
// transmitter reports txdone, so bytes are never dropped or repeated.
// Optionally waits GAP_CYCLES idle cycles after every txdone.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : rom_uart_streamer_if.master (start, ROM port, UART handshake,
//         busy/done status)
// ----------------------------------------------------------------------------
module rom_uart_streamer #(
    parameter int ADDR_W     = 13,
    parameter int LAST_WORD  = 8191,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    rom_uart_streamer_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_WORD);
    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int                GAP_W     = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_ADVANCE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        idx_q,   idx_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [31:0]       word_q,  word_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets a hold default before the case,
        // so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        word_d  = word_q;

        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            // Address has been presented; the ROM answers one clock later.
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                word_d  = bus.mem_rd;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            // txdone is only honoured here, which also discards a pulse that
            // coincides with senddata (that cycle is S_SEND).
            S_WAIT: begin
                if (bus.txdone) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_ADVANCE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_ADVANCE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_ADVANCE: begin
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SEND;
                end else if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end else begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from registered state so they clear the moment
    // reset is asserted.
    assign bus.mem_addr = addr_q;
    assign bus.txbyte   = word_q[{idx_q, 3'b000} +: 8];
    assign bus.senddata = (state_q == S_SEND);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_ADVANCE) && (idx_q == 2'd3) && (addr_q == LAST_ADDR);
endmodule

// File: tb/tb_rom_uart_streamer.sv
// ----------------------------------------------------------------------------
// tb_rom_uart_streamer
// Two streamer instances share clock and reset:
//   dut_a : LAST_WORD=1, GAP_CYCLES=0 (two words, word-boundary timing)
//   dut_g : LAST_WORD=0, GAP_CYCLES=5 (single word, gap insertion)
// Expected bytes are the ROM words split LSB first; expected senddata cycles
// follow the start/txdone latency rules. Inputs change and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_rom_uart_streamer;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_uart_streamer_if #(.ADDR_W(AW)) ifa ();
    rom_uart_streamer_if #(.ADDR_W(AW)) ifg ();

    rom_uart_streamer #(.ADDR_W(AW), .LAST_WORD(1), .GAP_CYCLES(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    rom_uart_streamer #(.ADDR_W(AW), .LAST_WORD(0), .GAP_CYCLES(5)) dut_g (
        .clk (clk),
        .rst (rst),
        .bus (ifg)
    );

    // Synchronous ROMs: data appears one clock after the address.
    logic [31:0] rom_a [16];
    logic [31:0] rom_g [16];
    always @(posedge clk) begin
        ifa.mem_rd <= rom_a[ifa.mem_addr];
        ifg.mem_rd <= rom_g[ifg.mem_addr];
    end

    // Event monitors: senddata/done pulse counts and highest address seen.
    int sd_cnt   [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int max_addr [2] = '{0, 0};
    always @(negedge clk) begin
        if (ifa.senddata === 1'b1) sd_cnt[0]++;
        if (ifg.senddata === 1'b1) sd_cnt[1]++;
        if (ifa.done === 1'b1) done_cnt[0]++;
        if (ifg.done === 1'b1) done_cnt[1]++;
        if (int'(ifa.mem_addr) > max_addr[0]) max_addr[0] = int'(ifa.mem_addr);
        if (int'(ifg.mem_addr) > max_addr[1]) max_addr[1] = int'(ifg.mem_addr);
    end

    function automatic logic get_sd(input int s);
        return (s == 1) ? ifg.senddata : ifa.senddata;
    endfunction
    function automatic logic [7:0] get_tb(input int s);
        return (s == 1) ? ifg.txbyte : ifa.txbyte;
    endfunction
    function automatic logic get_busy(input int s);
        return (s == 1) ? ifg.busy : ifa.busy;
    endfunction
    function automatic logic get_done(input int s);
        return (s == 1) ? ifg.done : ifa.done;
    endfunction
    function automatic int get_addr(input int s);
        return (s == 1) ? int'(ifg.mem_addr) : int'(ifa.mem_addr);
    endfunction

    task automatic set_td(input int s, input logic v);
        if (s == 1) ifg.txdone = v;
        else        ifa.txdone = v;
    endtask
    task automatic set_start(input int s, input logic v);
        if (s == 1) ifg.start = v;
        else        ifa.start = v;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Transmitter model for one byte: wait for senddata, check byte and timing,
    // hold the frame for 'delay' cycles, then pulse txdone once.
    task automatic serve(input int s, input int delay, input int exp_cyc,
                         input logic [7:0] exp_b, input bit spur, output int td_cyc);
        int waited;
        bit ok;
        waited = 0;
        while (get_sd(s) !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("senddata_seen", get_sd(s), 1);
        check("senddata_cycle", cyc, exp_cyc);
        check("txbyte", get_tb(s), exp_b);
        if (spur) set_td(s, 1'b1);  // txdone alongside senddata must be ignored
        ok = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            set_td(s, 1'b0);
            if (get_sd(s) !== 1'b0 || get_tb(s) !== exp_b ||
                get_done(s) !== 1'b0 || get_busy(s) !== 1'b1) ok = 1'b0;
        end
        check("hold_in_wait", ok, 1);
        set_td(s, 1'b1);
        td_cyc = cyc;
        @(negedge clk);
        set_td(s, 1'b0);
    endtask

    // One dump against the reference byte stream built from the ROM image.
    task automatic dump(input int s, input bit do_start, input int first_cyc,
                        input int stop_at, input bit spur, input int stall_byte,
                        input int fixed_delay, input bit hold_start, output int done_cyc);
        int last, gap, nbytes, exp_c, td, d, sd0, dn0;
        logic [7:0] exp_q [$];
        logic [31:0] word;
        last = (s == 1) ? 0 : 1;
        gap  = (s == 1) ? 5 : 0;
        exp_q = {};
        for (int w = 0; w <= last; w++) begin
            word = (s == 1) ? rom_g[w] : rom_a[w];
            for (int b = 0; b < 4; b++) exp_q.push_back(word[8*b +: 8]);
        end
        nbytes   = (stop_at < 0) ? exp_q.size() : stop_at;
        sd0      = sd_cnt[s];
        dn0      = done_cnt[s];
        done_cyc = 0;
        if (do_start) begin
            exp_c = cyc + 3;
            set_start(s, 1'b1);
            if (spur) set_td(s, 1'b1);  // stray txdone in IDLE and FETCH
            @(negedge clk);
            check("busy_after_start", get_busy(s), 1);
            check("addr_first_fetch", get_addr(s), 0);
            if (!hold_start) set_start(s, 1'b0);
            @(negedge clk);
            set_td(s, 1'b0);
        end else begin
            exp_c = first_cyc;
        end
        for (int i = 0; i < nbytes; i++) begin
            d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 12));
            if (i == stall_byte) d = 1000;
            serve(s, d, exp_c, exp_q[i], spur && (i == 0), td);
            if (!do_start && i == 0) set_start(s, 1'b0);
            if (spur && i == 1) begin
                set_start(s, 1'b1);  // start while busy must be ignored
                @(negedge clk);
                set_start(s, 1'b0);
            end
            exp_c = td + 2 + gap + ((((i + 1) % 4) == 0) ? 2 : 0);
        end
        if (stop_at < 0) begin
            repeat (gap) @(negedge clk);
            check("done_pulse", get_done(s), 1);
            check("busy_with_done", get_busy(s), 1);
            done_cyc = cyc;
            @(negedge clk);
            check("done_single", get_done(s), 0);
            check("busy_idle", get_busy(s), 0);
            check("addr_idle", get_addr(s), 0);
            check("senddata_count", sd_cnt[s] - sd0, nbytes);
            check("done_count", done_cnt[s] - dn0, 1);
        end
    endtask

    initial begin
        int dc, dc2, waited;
        bit ok;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.txdone = 1'b0;
        ifg.start = 1'b0; ifg.txdone = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = $urandom;
            rom_g[i] = $urandom;
        end
        repeat (3) @(negedge clk);
        check("rst_addr", ifa.mem_addr, 0);
        check("rst_txbyte", ifa.txbyte, 0);
        check("rst_senddata", ifa.senddata, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", ifa.busy, 0);

        // Basic word: 0x11, 0x22, 0x33, 0x44 first.
        rom_a[0] = 32'h4433_2211;
        dump(0, 1'b1, 0, -1, 1'b0, -1, 10, 1'b0, dc);

        // Word boundary and latency.
        rom_a[0] = 32'h0302_0100;
        rom_a[1] = 32'h0706_0504;
        dump(0, 1'b1, 0, -1, 1'b0, -1, 10, 1'b0, dc);

        // Gap insertion with a single-word dump.
        rom_g[0] = $urandom;
        dump(1, 1'b1, 0, -1, 1'b0, -1, 0, 1'b0, dc);

        // Handshake robustness: stray txdone, start while busy, long stall.
        rom_a[0] = $urandom;
        rom_a[1] = $urandom;
        dump(0, 1'b1, 0, -1, 1'b1, 5, 0, 1'b0, dc);
        rom_g[0] = $urandom;
        dump(1, 1'b1, 0, -1, 1'b1, 2, 0, 1'b0, dc);

        // Start held across done: second dump begins 4 cycles after done.
        rom_a[0] = 32'h4433_2211;
        rom_a[1] = $urandom;
        dump(0, 1'b1, 0, -1, 1'b0, -1, 0, 1'b1, dc);
        dump(0, 1'b0, dc + 4, -1, 1'b0, -1, 0, 1'b0, dc2);

        // Reset in WAIT on byte 2 of word 1.
        rom_a[0] = $urandom;
        rom_a[1] = $urandom;
        dump(0, 1'b1, 0, 6, 1'b0, -1, 0, 1'b0, dc);
        waited = 0;
        while (ifa.senddata !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rst_test_byte", ifa.txbyte, rom_a[1][23:16]);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_senddata", ifa.senddata, 0);
        check("async_busy", ifa.busy, 0);
        check("async_addr", ifa.mem_addr, 0);
        check("async_txbyte", ifa.txbyte, 0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (ifa.senddata !== 1'b0 || ifa.busy !== 1'b0) ok = 1'b0;
        end
        check("quiet_after_reset", ok, 1);
        dump(0, 1'b1, 0, -1, 1'b0, -1, 0, 1'b0, dc);

        check("max_addr_a", max_addr[0], 1);
        check("max_addr_g", max_addr[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
